// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - runtime-programmable integer clock divider; optional CLK_DIV_ODD_DUTY50_EN gives 50% duty for odd divisors
module clk_div_n #(
    parameter int DIV_W   = 4,
    parameter int DIV_RST = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             load_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             load_ack_o,
    output logic [DIV_W-1:0] div_o
);

    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             p_q, p_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic [DIV_W-1:0] div_clamp;
    logic [DIV_W-1:0] half_d;
    logic             wrap;
    logic             apply;

    // Next-state decode: counter wrap, pending-divisor capture and apply at the period boundary
    always_comb begin
        div_clamp  = (div_i < DIV_MIN) ? DIV_MIN : div_i;
        wrap       = (cnt_q == (div_q - ONE));
        // A load on the boundary edge replaces the pending value and is held for the next boundary
        apply      = wrap & pend_vld_q & ~load_i;
        cnt_d      = wrap ? '0 : (cnt_q + ONE);
        div_d      = apply ? pend_q : div_q;
        pend_d     = load_i ? div_clamp : pend_q;
        pend_vld_d = load_i ? 1'b1 : (apply ? 1'b0 : pend_vld_q);
        // High phase uses the divisor active for the cycle being entered, so a switch never runts
        half_d     = div_d >> 1;
        p_d        = (cnt_d < half_d);
        tick_d     = wrap;
        ack_d      = apply;
    end

    // Posedge state with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            div_q      <= DIV_RST_V;
            pend_q     <= DIV_RST_V;
            pend_vld_q <= 1'b0;
            p_q        <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            p_q        <= p_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic n_q;

    // Half-cycle delayed copy of p_q stretches the high phase by half a period for odd divisors
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

    assign clk_o = div_q[0] ? (p_q | n_q) : p_q;
`else
    assign clk_o = p_q;
`endif

    assign tick_o     = tick_q;
    assign load_ack_o = ack_q;
    assign div_o      = div_q;

endmodule
